// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit multiply/divide unit, one radix-2 step per cycle
module mult_div_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] Port_A,
  input  logic [31:0] Port_B,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic        is_div;
  logic        sa, sb, b_zero;
  logic [31:0] a_mag, b_mag;
  logic [63:0] acc;

  logic        signed_in, a_neg_in, b_neg_in;
  logic [31:0] a_mag_in, b_mag_in;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] q_raw, r_raw, quo_fix, rem_fix, a_raw;

  always_comb begin
    signed_in = ~op[0];
    a_neg_in  = signed_in & Port_A[31];
    b_neg_in  = signed_in & Port_B[31];
    a_mag_in  = a_neg_in ? -Port_A : Port_A;
    b_mag_in  = b_neg_in ? -Port_B : Port_B;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
    mul_next  = {mul_sum, acc[31:1]};

    // Divide: acc = {remainder, dividend/quotient}; the shifted remainder needs 33 bits.
    div_shift = acc[63:31];
    div_ge    = div_shift >= {1'b0, b_mag};
    div_diff  = div_shift[31:0] - b_mag;
    div_next  = div_ge ? {div_diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};

    prod_fix  = (sa ^ sb) ? -acc : acc;
    q_raw     = acc[31:0];
    r_raw     = acc[63:32];
    quo_fix   = (sa ^ sb) ? -q_raw : q_raw;
    rem_fix   = sa ? -r_raw : r_raw;
    a_raw     = sa ? -a_mag : a_mag;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= 6'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      div_by_zero <= 1'b0;
      is_div      <= 1'b0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      b_zero      <= 1'b0;
      a_mag       <= 32'd0;
      b_mag       <= 32'd0;
      acc         <= 64'd0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            is_div <= op[1];
            sa     <= a_neg_in;
            sb     <= b_neg_in;
            b_zero <= (Port_B == 32'd0);
            a_mag  <= a_mag_in;
            b_mag  <= b_mag_in;
            acc    <= op[1] ? {32'd0, a_mag_in} : {32'd0, b_mag_in};
            cnt    <= 6'd0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          if (is_div && b_zero) begin
            hi          <= a_raw;
            lo          <= 32'hFFFF_FFFF;
            div_by_zero <= 1'b1;
          end else if (is_div) begin
            hi          <= rem_fix;
            lo          <= quo_fix;
            div_by_zero <= 1'b0;
          end else begin
            hi          <= prod_fix[63:32];
            lo          <= prod_fix[31:0];
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          state <= DONE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] Port_A = 32'd0;
  logic [31:0] Port_B = 32'd0;
  logic        flush = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  mult_div_unit dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .Port_A(Port_A), .Port_B(Port_B),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          e0;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        chk("latency", cyc - e.e0, 33);
      end
    end
  end

  // Called at a negedge; the start edge is the next posedge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int e0);
    start  = 1'b1;
    op     = o;
    Port_A = a;
    Port_B = b;
    e0     = cyc + 1;
    @(negedge CLK);
    start  = 1'b0;
    Port_A = $urandom;
    Port_B = $urandom;
  endtask

  task automatic finish_op();
    bit seen = 1'b0;
    bit busy_ok = 1'b1;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        @(negedge CLK);
      end
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("busy_throughout", {31'd0, busy_ok}, 32'd1);
    @(negedge CLK);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input logic ed);
    int e0;
    exp_t e;
    e.hi = eh; e.lo = el; e.dbz = ed; e.e0 = cyc + 1;
    sb.push_back(e);
    issue(o, a, b, e0);
    finish_op();
  endtask

  initial begin
    int e0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    RST = 1'b0;

    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run(2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run(2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run(2'b11, 32'd10,        32'd0,        32'h0000_000A, 32'hFFFF_FFFF, 1'b1);
    run(2'b01, 32'd2,         32'd3,        32'd0,         32'd6,         1'b0);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0);
    run(2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0);
    run(2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

    // Flush on the 10th edge after start: no done, results untouched.
    issue(2'b01, 32'd7, 32'd9, e0);
    repeat (9) @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_hi", hi, 32'hFFFF_FFFB);
    chk("flush_lo", lo, 32'hFFFF_FFFF);
    chk("flush_dbz", {31'd0, div_by_zero}, 32'd1);
    repeat (40) @(negedge CLK);
    chk("flush_hi_later", hi, 32'hFFFF_FFFB);

    run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0);

    // A second start while busy must be ignored.
    begin
      exp_t e;
      e.hi = 32'd0; e.lo = 32'd20; e.dbz = 1'b0; e.e0 = cyc + 1;
      sb.push_back(e);
      issue(2'b01, 32'd4, 32'd5, e0);
      repeat (4) @(negedge CLK);
      start = 1'b1; op = 2'b11; Port_A = 32'd100; Port_B = 32'd3;
      @(negedge CLK);
      start = 1'b0;
      finish_op();
      repeat (40) @(negedge CLK);
    end

    // Reset asserted mid-divide clears everything at once.
    issue(2'b10, 32'd1000, 32'd7, e0);
    repeat (19) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    run(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    repeat (5) @(negedge CLK);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: CLK and RST, listed first.
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port RST  input  1  asynchronous active-high reset.
REQ-004 SHALL have port start  input  1  request an operation, sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port Port_A  input  32  operand A (dividend or multiplicand), the same EX-stage operand driven to the ALU.
REQ-007 SHALL have port Port_B  input  32  operand B (divisor or multiplier).
REQ-008 SHALL have port flush  input  1  synchronous abort of the current operation.
REQ-009 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port hi  output  32  HI result (product upper word, or remainder).
REQ-012 SHALL have port lo  output  32  LO result (product lower word, or quotient).
REQ-013 SHALL have port div_by_zero  output  1  last completed divide had Port_B == 0.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX and DONE.
REQ-015 SHALL, on an edge in IDLE with start=1 and flush=0:
- latch op and operand magnitudes (absolute values for MULT/DIV, raw values for MULTU/DIVU);
- latch both operand signs;
- clear the 6-bit iteration counter;
- go to CALC.
REQ-016 SHALL, in CALC, perform one radix-2 iteration per cycle:
- multiply: shift-add over a 64-bit accumulator;
- divide: restoring shift-subtract with a 33-bit partial remainder.
REQ-017 SHALL leave CALC for FIX on the edge that completes iteration 32.
REQ-018 SHALL, on the FIX edge, apply sign correction, write hi/lo and div_by_zero, and go to DONE; DONE lasts exactly one cycle, then IDLE.
REQ-019 SHALL assert done only in DONE, so done is high between edges E0+33 and E0+34, where E0 is the start-sampling edge.
REQ-020 SHALL compute signed MULT as a 64-bit two's-complement product, negated when sign A xor sign B; MULTU SHALL be an unsigned 64-bit product; product is {hi,lo}.
REQ-021 SHALL truncate signed DIV toward zero: quotient negated when sign A xor sign B; remainder takes sign A; DIVU SHALL be unsigned.
REQ-022 SHALL, for DIV -2^31 / -1, return lo=0x80000000, hi=0.
REQ-023 SHALL, for a divide with Port_B=0: hi=Port_A as latched, lo=0xFFFFFFFF, div_by_zero=1, same latency.
REQ-024 SHALL clear div_by_zero on completion of any multiply or nonzero-divisor divide.
REQ-025 SHALL ignore start while busy=1; operands are captured only at the start edge, so later operand changes have no effect.
REQ-026 SHALL, on an edge with flush=1 in any state, go to IDLE with no done pulse and leave hi/lo/div_by_zero unchanged; flush overrides start in IDLE.
REQ-027 SHALL hold hi/lo/div_by_zero stable outside the FIX edge.

Reset
REQ-028 SHALL, on RST=1 (asynchronous), force state IDLE, counter 0, busy=0, done=0, hi=0, lo=0, div_by_zero=0, including mid-operation.
REQ-029 SHALL accept a new start on the first edge after RST deasserts.

Verification
REQ-030 SHALL cover: MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 cycles after the start edge, busy high throughout.
REQ-031 SHALL cover: MULT A=-3, B=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 SHALL cover: DIVU A=10, B=0 -> hi=0x0000000A, lo=0xFFFFFFFF, div_by_zero=1; a following MULTU 2*3 -> lo=6, hi=0, div_by_zero=0.
REQ-033 SHALL cover: DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 SHALL cover: start MULTU 7*9, flush at cycle 10 -> no done, hi/lo keep prior values; start pulsed again at cycle 5 of a new op -> ignored, single done at cycle 33.
REQ-035 SHALL cover: RST asserted at cycle 20 of a divide -> outputs zero immediately, no done; a new DIVU 100/7 after release -> lo=14, hi=2.
